// File: rtl/bcd_event_counter_pkg.sv
// Shared constants for the seven-segment display path: FSM encodings and BCD limits.
// Imported by the event counter, the display driver and later counter variants.
package bcd_event_counter_pkg;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_HOLD = 2'b10;
   localparam logic [1:0] S_BAD  = 2'b11;

   localparam logic [3:0] BCD_NINE = 4'd9;
   localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/bcd_event_counter_debouncer.sv
// Synchronizes and debounces a raw active-high board button; emits the stable level
// and a one-cycle pulse on each accepted 0->1 change.
module button_debouncer #(
   parameter int DB_CYCLES   = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   sample;

   assign sample = sync[SYNC_STAGES-1];

   // The counter only advances while the sample disagrees with the accepted level;
   // any return to agreement restarts the stability window.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync       <= '0;
         cnt        <= '0;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], raw};
         rise_pulse <= 1'b0;
         if (sample == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt        <= '0;
            level      <= sample;
            rise_pulse <= sample;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_event_counter.sv
// Counts trigger events as four packed BCD digits for the display driver; a debounced
// button cycles IDLE -> RUN -> HOLD -> IDLE (start / freeze / clear).
module bcd_event_counter
   import bcd_event_counter_pkg::*;
#(
   parameter int DB_CYCLES   = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        trigger,
   input  logic        button,
   output logic [15:0] big_bin,
   output logic        running,
   output logic        overflow
);

   logic [SYNC_STAGES-1:0] trig_sync;
   logic                   trig_hist;
   logic                   trig_p;
   logic                   btn_level;
   logic                   btn_p;

   logic [1:0]                       state, state_nxt;
   logic [NUM_DIGITS-1:0][3:0]       digit, digit_nxt;
   logic [NUM_DIGITS:0]              carry;

   button_debouncer #(
      .DB_CYCLES   (DB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_btn (
      .clock      (clock),
      .reset      (reset),
      .raw        (button),
      .level      (btn_level),
      .rise_pulse (btn_p)
   );

   // trig_p is registered so an edge lands in big_bin SYNC_STAGES+1 cycles after sampling.
   always_ff @(posedge clock) begin
      if (reset) begin
         trig_sync <= '0;
         trig_hist <= 1'b0;
         trig_p    <= 1'b0;
      end else begin
         trig_sync <= {trig_sync[SYNC_STAGES-2:0], trigger};
         trig_hist <= trig_sync[SYNC_STAGES-1];
         trig_p    <= trig_sync[SYNC_STAGES-1] & ~trig_hist;
      end
   end

   assign carry[0] = 1'b1;
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign carry[g+1]   = carry[g] & (digit[g] == BCD_NINE);
      assign digit_nxt[g] = !carry[g]             ? digit[g] :
                            (digit[g] == BCD_NINE) ? 4'd0     : digit[g] + 4'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (btn_p) state_nxt = S_RUN;
         S_RUN:   if (btn_p) state_nxt = S_HOLD;
         S_HOLD:  if (btn_p) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         digit    <= '0;
         overflow <= 1'b0;
         running  <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == S_RUN);
         case (state)
            S_IDLE: digit <= '0;
            S_RUN: begin
               if (trig_p) begin
                  digit <= digit_nxt;
                  if (carry[NUM_DIGITS]) overflow <= 1'b1;
               end
            end
            S_HOLD: begin
               if (btn_p) begin
                  digit    <= '0;
                  overflow <= 1'b0;
               end
            end
            default: digit <= '0;
         endcase
      end
   end

   assign big_bin = digit;

endmodule
